// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//
// Purpose:
//   Bundles the requester-side handshake and the FIFO write-port signals of
//   fifo_wr_arbiter into one interface. Clock and reset stay outside as plain
//   module ports.
//
// Parameters:
//   NREQ   number of requesters
//   WIDTH  data width of one beat (matches the FIFO data width)
//   CNT_W  width of the accepted-beat statistics counter
//
// Signals:
//   req            requester -> arbiter   per-requester write request
//   wrdata         requester -> arbiter   requester k data at [k*WIDTH +: WIDTH]
//   fifo_full      FIFO      -> arbiter   FIFO full flag
//   fifo_alm_full  FIFO      -> arbiter   FIFO almost-full flag (>= 2 free slots)
//   gnt            arbiter   -> requester registered one-hot grant or zero
//   ack            arbiter   -> requester beat on wrdata[k] taken this cycle
//   fifo_wren      arbiter   -> FIFO      registered write enable
//   fifo_wrdata    arbiter   -> FIFO      registered write data
//   busy           arbiter   -> status    1 while a burst is granted
//   beat_cnt_total arbiter   -> status    running count of accepted beats
//
// Modports:
//   slave   the arbiter's view
//   master  the environment's view (requesters, FIFO flags, status reader)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 128,
    parameter int CNT_W = 32
) ();

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wrdata;
    logic                  fifo_full;
    logic                  fifo_alm_full;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  fifo_wren;
    logic [WIDTH-1:0]      fifo_wrdata;
    logic                  busy;
    logic [CNT_W-1:0]      beat_cnt_total;

    modport slave (
        input  req,
        input  wrdata,
        input  fifo_full,
        input  fifo_alm_full,
        output gnt,
        output ack,
        output fifo_wren,
        output fifo_wrdata,
        output busy,
        output beat_cnt_total
    );

    modport master (
        output req,
        output wrdata,
        output fifo_full,
        output fifo_alm_full,
        input  gnt,
        input  ack,
        input  fifo_wren,
        input  fifo_wrdata,
        input  busy,
        input  beat_cnt_total
    );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Round-robin arbiter sharing one FIFO write port among NREQ requesters.
//   A winner is granted for a burst of up to MAX_BURST accepted beats. Every
//   accepted beat is registered onto fifo_wren/fifo_wrdata one cycle later.
//   Any almost-full or full indication stalls acceptance; because at most one
//   beat is ever in flight and almost-full still leaves two free slots, the
//   FIFO cannot overflow.
//
// State table:
//   state | meaning
//   IDLE  | no grant; picks the next winner when a request is present and
//         | the FIFO is not throttling
//   BURST | one requester granted; beats accepted while not stalled; leaves
//         | after MAX_BURST beats or when the winner drops its request
//
// Ports:
//   clk   in  clock, all state updates on the rising edge
//   rstn  in  asynchronous reset, active HIGH despite the name
//   bus   slave modport of fifo_wr_arbiter_if (request/ack, FIFO write port,
//         status outputs)
//
// Parameters:
//   NREQ       number of requesters (2..8)
//   WIDTH      beat data width
//   MAX_BURST  maximum accepted beats per grant (1..256)
//   CNT_W      width of beat_cnt_total
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 128,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rstn,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    // The burst counter only has to reach MAX_BURST-1: the final beat ends the
    // burst instead of being counted.
    localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);
    localparam logic [BC_W-1:0]  BURST_END = BC_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]  last_winner_q, last_winner_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic              wren_q, wren_d;
    logic [WIDTH-1:0]  wrdata_q, wrdata_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic              stall;
    logic              accept;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [NREQ-1:0]   ack;
    logic [WIDTH-1:0]  req_data [NREQ];

    // -------------------------------------------------------------------------
    // Input unpacking and throttle
    // -------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            req_data[k] = bus.wrdata[k*WIDTH +: WIDTH];
        end
    end

    assign stall = bus.fifo_alm_full | bus.fifo_full;

    // -------------------------------------------------------------------------
    // Round-robin winner search: first requester with req set, starting just
    // after the previous winner and wrapping modulo NREQ. The previous winner
    // itself is checked last, so a lone requester still wins every time.
    // -------------------------------------------------------------------------
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand     = (int'(last_winner_q) + i) % NREQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && bus.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Acceptance: only the granted requester, only in BURST, only unstalled.
    // gnt_q is one-hot, so accept is a single-beat event.
    // -------------------------------------------------------------------------
    assign ack    = (state_q == BURST && !stall) ? (gnt_q & bus.req) : '0;
    assign accept = |ack;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_winner_d = last_winner_q;
        burst_cnt_d   = burst_cnt_q;
        wren_d        = 1'b0;
        wrdata_d      = wrdata_q;
        beat_cnt_d    = beat_cnt_q;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_found && !stall) begin
                    state_d       = BURST;
                    gnt_d         = NREQ'(1) << win_idx;
                    last_winner_d = win_idx;
                    burst_cnt_d   = '0;
                end
            end

            BURST: begin
                if (accept) begin
                    wren_d      = 1'b1;
                    wrdata_d    = req_data[last_winner_q];
                    beat_cnt_d  = beat_cnt_q + CNT_W'(1);
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                end
                // A dropped request ends the burst even while stalled.
                if ((accept && burst_cnt_q == BURST_END) || !bus.req[last_winner_q]) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    burst_cnt_d = '0;
                end
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                burst_cnt_d = '0;
            end
        endcase

        busy_d = (state_d == BURST);
    end

    // -------------------------------------------------------------------------
    // State registers. Reset clears the in-flight beat immediately.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            last_winner_q <= LAST_IDX;
            burst_cnt_q   <= '0;
            wren_q        <= 1'b0;
            wrdata_q      <= '0;
            busy_q        <= 1'b0;
            beat_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_winner_q <= last_winner_d;
            burst_cnt_q   <= burst_cnt_d;
            wren_q        <= wren_d;
            wrdata_q      <= wrdata_d;
            busy_q        <= busy_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.gnt            = gnt_q;
    assign bus.ack            = ack;
    assign bus.fifo_wren      = wren_q;
    assign bus.fifo_wrdata    = wrdata_q;
    assign bus.busy           = busy_q;
    assign bus.beat_cnt_total = beat_cnt_q;

endmodule
